// File: rtl/pc_unit_if.sv
// Control/data bundle between the decode/execute side and the PC unit.
interface pc_unit_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 stall;
  logic                 branch_taken;
  logic [WIDTH-1:0]     ImmOp;
  logic                 jalr;
  logic [WIDTH-1:0]     jalr_base;
  logic                 trap;
  logic [WIDTH-1:0]     trap_vector;
  logic [WIDTH-1:0]     PC;
  logic [WIDTH-1:0]     PC_plus4;
  logic                 redirect_pending;
  logic                 misaligned;
  logic [CNT_WIDTH-1:0] fetch_count;

  // Requester side: drives control and redirect operands, observes PC state.
  modport master (
    output stall, branch_taken, ImmOp, jalr, jalr_base, trap, trap_vector,
    input  PC, PC_plus4, redirect_pending, misaligned, fetch_count
  );

  // PC unit side.
  modport slave (
    input  stall, branch_taken, ImmOp, jalr, jalr_base, trap, trap_vector,
    output PC, PC_plus4, redirect_pending, misaligned, fetch_count
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with priority redirect (trap > jalr > branch), a one-entry
// redirect buffer that holds a target raised while stalled, and a saturating
// fetch counter.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               CNT_WIDTH    = 16
) (
  input logic         clk,
  input logic         rst,
  pc_unit_if.slave    bus
);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} buf_state_e;

  buf_state_e           state_q;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     buf_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 redir;
  logic [WIDTH-1:0]     tgt;
  logic [WIDTH-1:0]     jalr_tgt;

  assign redir    = bus.trap | bus.jalr | bus.branch_taken;
  assign jalr_tgt = (bus.jalr_base + bus.ImmOp) & ~{{(WIDTH-1){1'b0}}, 1'b1};

  // Fixed-priority target select among this cycle's redirect requests.
  always_comb begin
    tgt = pc_q + bus.ImmOp;
    if (bus.trap)      tgt = bus.trap_vector;
    else if (bus.jalr) tgt = jalr_tgt;
  end

  // Next PC when not stalled: fresh redirect beats buffered one beats +4.
  always_comb begin
    pc_d = pc_q + WIDTH'(4);
    if (redir)                pc_d = tgt;
    else if (state_q == HELD) pc_d = buf_q;
  end

  // PC, buffer FSM and fetch counter; reset overrides stall and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      buf_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (!bus.stall) begin
      pc_q    <= pc_d;
      state_q <= IDLE;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end else if (redir) begin
      // Latest redirect within a stall overwrites any earlier one.
      buf_q   <= tgt;
      state_q <= HELD;
    end
  end

  assign bus.PC               = pc_q;
  assign bus.PC_plus4         = pc_q + WIDTH'(4);
  assign bus.redirect_pending = (state_q == HELD);
  assign bus.misaligned       = (pc_q[1:0] != 2'b00);
  assign bus.fetch_count      = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes the model's expected state
// after each edge; a monitor pops and compares after every edge. A second
// instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_pc_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32), .CNT_WIDTH(16)) bus  ();
  pc_unit_if #(.WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  assign bus2.stall        = bus.stall;
  assign bus2.branch_taken = bus.branch_taken;
  assign bus2.ImmOp        = bus.ImmOp;
  assign bus2.jalr         = bus.jalr;
  assign bus2.jalr_base    = bus.jalr_base;
  assign bus2.trap         = bus.trap;
  assign bus2.trap_vector  = bus.trap_vector;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_pc  = 32'h0;
  logic        m_pend = 1'b0;
  logic [31:0] m_buf = 32'h0;
  int unsigned m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] imm,
                     input logic j, input logic [31:0] base, input logic t,
                     input logic [31:0] tv);
    logic [31:0] target;
    exp_t e;
    @(negedge clk);
    rst = r; bus.stall = s; bus.branch_taken = b; bus.ImmOp = imm;
    bus.jalr = j; bus.jalr_base = base; bus.trap = t; bus.trap_vector = tv;
    if (t)      target = tv;
    else if (j) target = (base + imm) & 32'hFFFF_FFFE;
    else        target = m_pc + imm;
    if (r) begin
      m_pc = 32'h0; m_pend = 1'b0; m_buf = 32'h0; m_cnt = 0;
    end else if (!s) begin
      if (t || j || b) m_pc = target;
      else if (m_pend) m_pc = m_buf;
      else             m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
      m_cnt++;
    end else if (t || j || b) begin
      m_buf = target; m_pend = 1'b1;
    end
    e.pc = m_pc; e.pend = m_pend; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("PC", bus.PC, e.pc);
        chk("PC_plus4", bus.PC_plus4, e.pc + 32'd4);
        chk("misaligned", {31'b0, bus.misaligned}, {31'b0, e.pc[1:0] != 2'b00});
        chk("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, e.pend});
        chk("fetch_count", {16'b0, bus.fetch_count}, (e.cnt > 65535) ? 32'd65535 : e.cnt);
        chk("fetch_count_sat2", {30'b0, bus2.fetch_count}, (e.cnt > 3) ? 32'd3 : e.cnt);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.branch_taken = 0; bus.ImmOp = 0; bus.jalr = 0;
    bus.jalr_base = 0; bus.trap = 0; bus.trap_vector = 0;

    // Reset, then sequential run
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h40, 1, 0, 1, 32'h300);
    free(3);                                      // 0x4, 0x8, 0xC
    free(1);                                      // 0x10
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);      // branch -> 0x08
    free(2);                                      // 0x10
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 1, 32'h100);// trap wins -> 0x100
    cyc(0, 0, 1, 32'h2, 1, 32'h2001, 0, 0);       // jalr -> 0x2002
    // Stall buffer: branch to 0x40, then jalr to 0x80 overwrites
    cyc(0, 1, 1, 32'h40 - 32'h2002, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 32'h80, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    free(1);                                      // -> 0x80
    free(1);
    // Buffered target discarded by fresh trap on release
    cyc(0, 1, 0, 0, 1, 32'h80, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h200);
    free(1);                                      // 0x204, not 0x80
    // Reset mid-stall with pending target
    cyc(0, 1, 1, 32'h100, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    free(5);                                      // 2-bit counter saturates at 3
    // Wrap-around
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    free(1);                                      // -> 0
    // Misaligned trap target still loaded
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0000_0123);
    free(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, s, b, j, t;
      logic [31:0] imm, base, tv;
      r    = ($urandom_range(0, 59) == 0);
      s    = ($urandom_range(0, 2) == 0);
      b    = ($urandom_range(0, 3) == 0);
      j    = ($urandom_range(0, 5) == 0);
      t    = ($urandom_range(0, 7) == 0);
      imm  = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 64)) - 32'd32);
      base = $urandom;
      tv   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc(r, s, b, imm, j, base, t, tv);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
